uart_input_manager: RTL



---
 rtl/uart_input_manager_if.sv | 19 +
 rtl/uart_input_manager.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_input_manager_if.sv
`default_nettype none
// ============================================================================
// uart_input_manager_if
// Serial input line and assembled-word outputs of the UART input manager.
// Revision: 1.0
// ============================================================================
interface uart_input_manager_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  RsRx;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  ready_out;
  logic                  error_out;

  // master: the word producer (the input manager itself)
  modport master (input RsRx, output data_out, output ready_out, output error_out);
  modport slave  (output RsRx, input data_out, input ready_out, input error_out);
endinterface
`default_nettype wire

// File: rtl/uart_input_manager.sv
`default_nettype none
// ============================================================================
// uart_input_manager
// 8N1 receiver + ASCII hex decoder assembling OPERAND_SIZE-digit operand words.
// Optional macro UART_IN_TIMEOUT_EN: abort a partial word after line-idle timeout.
// Revision: 1.0
// ============================================================================
module uart_input_manager #(
  parameter int OPERAND_SIZE = 4,
  parameter int CLOCK_RATE   = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int ASCII_SIZE   = 8,
  parameter int HEX_SIZE     = 4,
  parameter int TIMEOUT_BITS = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_input_manager_if.master        bus
);
  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (ASCII_SIZE > 1) ? $clog2(ASCII_SIZE) : 1;
  localparam int WORD_W = OPERAND_SIZE * HEX_SIZE;
  localparam int DIG_W  = $clog2(OPERAND_SIZE + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ASCII_SIZE - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(OPERAND_SIZE - 1);

  localparam logic [ASCII_SIZE-1:0] CH_0  = ASCII_SIZE'(8'h30);
  localparam logic [ASCII_SIZE-1:0] CH_9  = ASCII_SIZE'(8'h39);
  localparam logic [ASCII_SIZE-1:0] CH_UA = ASCII_SIZE'(8'h41);
  localparam logic [ASCII_SIZE-1:0] CH_UF = ASCII_SIZE'(8'h46);
  localparam logic [ASCII_SIZE-1:0] CH_LA = ASCII_SIZE'(8'h61);
  localparam logic [ASCII_SIZE-1:0] CH_LF_HEX = ASCII_SIZE'(8'h66);
  localparam logic [ASCII_SIZE-1:0] CH_CR = ASCII_SIZE'(8'h0D);
  localparam logic [ASCII_SIZE-1:0] CH_NL = ASCII_SIZE'(8'h0A);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_cfg_check
    $error("uart_input_manager: CLOCK_RATE/BAUD_RATE must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  rx_state_t              state, state_next;
  logic                   rx_meta, rx_sync;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [ASCII_SIZE-1:0]  rx_byte;
  logic                   byte_valid;
  logic                   baud_clr, shift_en, stop_good, stop_bad;

  logic [HEX_SIZE-1:0]    nib_c, dec_nib;
  logic                   bad_c, eol_c, dec_valid, dec_bad, dec_eol;

  logic [WORD_W-1:0]      shadow, shadow_ins, data_q;
  logic [DIG_W-1:0]       digit_cnt;
  logic                   sticky, ready_q, error_q;
  logic                   take_digit, word_done, word_abort, timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.RsRx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    baud_clr   = 1'b0;
    shift_en   = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          state_next = S_START;
          baud_clr   = 1'b1;
        end
      end
      S_START: begin
        if (baud_cnt == HALF_M1) begin
          baud_clr   = 1'b1;
          state_next = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == FULL_M1) begin
          baud_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_cnt == FULL_M1) begin
          baud_clr   = 1'b1;
          state_next = S_IDLE;
          stop_good  = rx_sync;
          stop_bad   = !rx_sync;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      if (baud_clr)               baud_cnt <= '0;
      else if (state != S_IDLE)   baud_cnt <= baud_cnt + 1'b1;
      if (state == S_START)       bit_cnt <= '0;
      else if (shift_en)          bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)               rx_byte <= {rx_sync, rx_byte[ASCII_SIZE-1:1]};
      byte_valid <= stop_good;
    end
  end

  always_comb begin
    nib_c = '0;
    bad_c = 1'b0;
    eol_c = 1'b0;
    if (rx_byte == CH_CR || rx_byte == CH_NL)         eol_c = 1'b1;
    else if (rx_byte >= CH_0  && rx_byte <= CH_9)     nib_c = HEX_SIZE'(rx_byte - CH_0);
    else if (rx_byte >= CH_UA && rx_byte <= CH_UF)    nib_c = HEX_SIZE'(rx_byte - CH_UA + ASCII_SIZE'(10));
    else if (rx_byte >= CH_LA && rx_byte <= CH_LF_HEX) nib_c = HEX_SIZE'(rx_byte - CH_LA + ASCII_SIZE'(10));
    else                                              bad_c = 1'b1;
  end

  // Registered decode stage places ready_out two cycles after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_nib   <= '0;
      dec_bad   <= 1'b0;
      dec_eol   <= 1'b0;
    end else begin
      dec_valid <= byte_valid;
      if (byte_valid) begin
        dec_nib <= nib_c;
        dec_bad <= bad_c;
        dec_eol <= eol_c;
      end
    end
  end

`ifdef UART_IN_TIMEOUT_EN
  localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_IDLE || digit_cnt == '0) idle_cnt <= '0;
    else if (idle_cnt != IDLE_W'(IDLE_LIMIT))        idle_cnt <= idle_cnt + 1'b1;
  end
  assign timeout_hit = (idle_cnt == IDLE_W'(IDLE_LIMIT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Unreceived nibbles of the shadow are always zero, so OR-ing inserts cleanly.
  always_comb begin
    shadow_ins = shadow | (WORD_W'(dec_nib) << (HEX_SIZE * int'(digit_cnt)));
    take_digit = dec_valid && !dec_eol;
    word_done  = take_digit && (digit_cnt == LAST_DIG);
    word_abort = (digit_cnt != '0) && ((dec_valid && dec_eol) || (!dec_valid && timeout_hit));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      digit_cnt <= '0;
      sticky    <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (word_done) begin
        data_q    <= shadow_ins;
        error_q   <= sticky || dec_bad;
        ready_q   <= 1'b1;
        shadow    <= '0;
        digit_cnt <= '0;
      end else if (word_abort) begin
        data_q    <= shadow;
        error_q   <= 1'b1;
        ready_q   <= 1'b1;
        shadow    <= '0;
        digit_cnt <= '0;
      end else if (take_digit) begin
        shadow    <= shadow_ins;
        digit_cnt <= digit_cnt + 1'b1;
      end
      if (word_done || word_abort)             sticky <= stop_bad;
      else if (stop_bad || (take_digit && dec_bad)) sticky <= 1'b1;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.ready_out = ready_q;
  assign bus.error_out = error_q;
endmodule
`default_nettype wire
